// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core types and constants for the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // Encoding of ADDI x0,x0,0; used downstream when a bubble is inserted
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch entries with flush; head is read
//               straight from storage, so a push is visible the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import core_pkg::*;
#(
    parameter int   DEPTH = 2,
    localparam int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage with credit-limited requests, in-order
//               responses, redirect flush/drop and a decode-side buffer.
//               Define FETCH_MISALIGN_CHECK_EN to fault on misaligned redirects.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 2;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] credit_used;
    logic [31:0]   target;
    logic          halted, req_fire, rsp_keep, push, pop;
    logic          fifo_full, fifo_empty;
    fetch_entry_t  push_entry, head_entry;

    assign target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            fault_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign halted = fault_q;
`else
    assign halted = 1'b0;
`endif

    assign fetch_fault = halted;

    // An entry leaving the buffer this cycle already counts as a free slot,
    // which is what lets a 1-cycle memory stream one instruction per cycle.
    assign pop         = if_valid && if_ready && !redirect_valid;
    assign credit_used = SW'(outst_q) + SW'(drop_q) + SW'(fifo_count) - SW'(pop);

    assign imem_req_valid = !rst && !halted && (credit_used < SW'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign push           = rsp_keep && (!fifo_full || pop);
    assign push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        if (redirect_valid) begin
            fetch_pc_d = target;
            rsp_pc_d   = target;
            outst_d    = '0;
            drop_d     = drop_q + outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (rsp_keep) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            outst_d = outst_q + CW'(req_fire) - CW'(rsp_keep);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign if_valid = !fifo_empty;
    assign if_instr = head_entry.instr;
    assign if_pc    = head_entry.pc;

endmodule
`default_nettype wire
